// File: rtl/lfsr_test_pkg.sv
// Shared types and helpers for the PRBS self-test sequencer and the generator/checker tops.
package lfsr_test_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StSeed,
    StAcquire,
    StMeasure,
    StDone
  } seq_state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lfsr_valid_pacer.sv
// Clock divider that produces the one-cycle pacing strobe for the generator/checker i_valid.
// The strobe is presented one cycle early so the owner can register it into its own output.
module lfsr_valid_pacer
  import lfsr_test_pkg::*;
#(
  parameter int unsigned Div = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  input  logic strobe_en_i,
  output logic strobe_o
);

  localparam int unsigned    CntW = cnt_width(Div);
  localparam logic [CntW-1:0] Last = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next divider value: sync clear wins, otherwise wrap at Div-1 while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  // Strobe for the coming cycle, when the divider lands on its last count.
  assign strobe_o = strobe_en_i && (cnt_d == Last);

  // Divider state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lfsr_test_sequencer.sv
// PRBS self-test sequencer: seeds the generator/checker pair, paces i_valid, waits for lock,
// counts lock losses over a fixed strobe window and reports pass/fail.
// Optional build macro ERR_INJECT_EN adds periodic o_corrupt pulses during MEASURE.
module lfsr_test_sequencer
  import lfsr_test_pkg::*;
#(
  parameter int unsigned NB_LFSR      = 8,
  parameter int unsigned VALID_DIV    = 4,
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned TEST_LEN     = 1024,
  parameter int unsigned NB_CNT       = 16
`ifdef ERR_INJECT_EN
  ,
  parameter int unsigned INJECT_PERIOD = 256
`endif
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_LFSR-1:0] i_seed,
  input  logic               i_lock,
  output logic [NB_LFSR-1:0] o_seed,
  output logic               o_soft_reset,
  output logic               o_valid,
  output logic               o_corrupt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [NB_CNT-1:0]  o_err_count
);

  localparam int unsigned      MaxStrb     = (LOCK_TIMEOUT > TEST_LEN) ? LOCK_TIMEOUT : TEST_LEN;
  localparam int unsigned      StrbW       = cnt_width(MaxStrb);
  localparam logic [StrbW-1:0] TimeoutLast = StrbW'(LOCK_TIMEOUT - 1);
  localparam logic [StrbW-1:0] MeasLast    = StrbW'(TEST_LEN - 1);

  seq_state_e         state_q, state_d;
  logic [StrbW-1:0]   strb_q, strb_d;
  logic [NB_LFSR-1:0] seed_q, seed_d;
  logic [NB_CNT-1:0]  err_q, err_d;
  logic               timeout_q, timeout_d;
  logic               pass_q, pass_d;
  logic               lock_q;
  logic               valid_q, soft_reset_q, busy_q, done_q;
  logic               strobe_next;
  logic               pacing_next;

  assign pacing_next = (state_d == StAcquire) || (state_d == StMeasure);

  lfsr_valid_pacer #(
    .Div (VALID_DIV)
  ) u_pacer (
    .clk_i       (clk),
    .rst_i       (i_rst),
    .clear_i     (state_q == StSeed),
    .en_i        ((state_q == StAcquire) || (state_q == StMeasure)),
    .strobe_en_i (pacing_next),
    .strobe_o    (strobe_next)
  );

  // Run sequencing; valid_q is the strobe being presented this cycle.
  always_comb begin
    state_d   = state_q;
    strb_d    = strb_q;
    seed_d    = seed_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    if (i_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (i_start) begin
            state_d   = StSeed;
            seed_d    = i_seed;
            err_d     = '0;
            timeout_d = 1'b0;
            pass_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
        StSeed: begin
          state_d = StAcquire;
          strb_d  = '0;
        end
        StAcquire: begin
          // Lock seen on the timeout strobe still counts as acquired.
          if (i_lock) begin
            state_d = StMeasure;
            strb_d  = '0;
          end else if (valid_q) begin
            if (strb_q == TimeoutLast) begin
              state_d   = StDone;
              timeout_d = 1'b1;
            end else begin
              strb_d = strb_q + 1'b1;
            end
          end
        end
        StMeasure: begin
          if (lock_q && !i_lock && (err_q != '1)) begin
            err_d = err_q + 1'b1;
          end
          if (valid_q) begin
            if (strb_q == MeasLast) begin
              state_d = StDone;
            end else begin
              strb_d = strb_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (state_d == StDone) begin
      pass_d = !timeout_d && (err_d == '0);
    end
  end

  // State, results and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      strb_q       <= '0;
      seed_q       <= '0;
      err_q        <= '0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
      lock_q       <= 1'b0;
      valid_q      <= 1'b0;
      soft_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      strb_q       <= strb_d;
      seed_q       <= seed_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
      lock_q       <= i_lock;
      valid_q      <= strobe_next;
      soft_reset_q <= (state_d == StSeed);
      busy_q       <= (state_d == StSeed) || pacing_next;
      done_q       <= (state_d == StDone);
    end
  end

`ifdef ERR_INJECT_EN
  localparam int unsigned     InjW    = cnt_width(INJECT_PERIOD);
  localparam logic [InjW-1:0] InjLast = InjW'(INJECT_PERIOD - 1);

  logic [InjW-1:0] inj_q, inj_d;
  logic            corrupt_q;

  // MEASURE strobes seen so far, modulo the inject period.
  always_comb begin
    inj_d = inj_q;
    if (state_q != StMeasure) begin
      inj_d = '0;
    end else if (valid_q) begin
      inj_d = (inj_q == InjLast) ? '0 : inj_q + 1'b1;
    end
  end

  // Corrupt pulse rides on every INJECT_PERIOD-th MEASURE strobe.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      inj_q     <= '0;
      corrupt_q <= 1'b0;
    end else begin
      inj_q     <= inj_d;
      corrupt_q <= (state_d == StMeasure) && strobe_next && (inj_d == InjLast);
    end
  end

  assign o_corrupt = corrupt_q;
`else
  assign o_corrupt = 1'b0;
`endif

  assign o_seed       = seed_q;
  assign o_soft_reset = soft_reset_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_timeout    = timeout_q;
  assign o_err_count  = err_q;

endmodule
